// File: rtl/bus_rr_arbiter.sv
// Multi-bus packet arbiter: each bus pops one device FIFO at a time (round-robin or fixed priority)
// and delivers the packet to one device or broadcasts it. Define ARB_DROP_CNT_EN to build the drop counters.
module bus_rr_arbiter #(
  parameter int         BITS      = 1,
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mode_rr,
  input  logic [BITS*DRVRS-1:0]         pndng,
  input  logic [BITS*DRVRS*PCKG_SZ-1:0] D_pop,
  output logic [BITS*DRVRS-1:0]         pop,
  output logic [BITS*DRVRS-1:0]         push,
  output logic [BITS*DRVRS*PCKG_SZ-1:0] D_push,
  output logic [BITS-1:0]               busy,
  output logic [BITS*16-1:0]            drop_cnt
);

  localparam int            IW       = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DRVRS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  for (genvar b = 0; b < BITS; b++) begin : g_bus
    state_t             r_state;
    state_t             w_state_nxt;
    logic [DRVRS-1:0]   w_req;
    logic               w_any;
    logic [IW-1:0]      w_winner;
    logic [IW-1:0]      r_grant;
    logic [IW-1:0]      r_rr_ptr;
    logic [PCKG_SZ-1:0] w_head;
    logic [7:0]         w_dest;
    logic [DRVRS-1:0]   w_pop_nxt;
    logic [DRVRS-1:0]   w_push_nxt;
    logic [DRVRS-1:0]   r_pop;
    logic [DRVRS-1:0]   r_push;
    logic [PCKG_SZ-1:0] r_pkt;
    logic               r_busy;

    assign w_req = pndng[b*DRVRS +: DRVRS];
    assign w_any = |w_req;

    // Winner search starts at rr_ptr in round-robin mode, at index 0 in fixed-priority mode.
    always_comb begin : arb
      logic v_found;
      int   v_idx;
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      v_found  = 1'b0;
      v_idx    = 0;
      w_winner = '0;
      for (int i = 0; i < DRVRS; i++) begin
        v_idx = mode_rr ? (int'(r_rr_ptr) + i) : i;
        if (v_idx >= DRVRS) v_idx = v_idx - DRVRS;
        if (!v_found && w_req[IW'(v_idx)]) begin
          v_found  = 1'b1;
          w_winner = IW'(v_idx);
        end
      end
    end

    // Head of the granted FIFO, held stable by the device until after the pop edge.
    always_comb begin
      w_head = '0;
      for (int d = 0; d < DRVRS; d++) begin
        if (IW'(d) == r_grant) w_head = D_pop[(b*DRVRS+d)*PCKG_SZ +: PCKG_SZ];
      end
    end

    assign w_dest = w_head[PCKG_SZ-1 -: 8];

    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
    end

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        S_IDLE:  if (w_any) w_state_nxt = S_POP;
        S_POP:   w_state_nxt = S_PUSH;
        S_PUSH:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Next values of the registered strobes; the push mask is decoded while still in POP.
    always_comb begin
      w_pop_nxt  = '0;
      w_push_nxt = '0;
      case (r_state)
        S_IDLE: if (w_any) w_pop_nxt[w_winner] = 1'b1;
        S_POP: begin
          if (w_dest == BROADCAST) begin
            w_push_nxt          = '1;
            w_push_nxt[r_grant] = 1'b0;
          end else if (int'(w_dest) < DRVRS && int'(w_dest) != int'(r_grant)) begin
            w_push_nxt[w_dest[IW-1:0]] = 1'b1;
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_grant  <= '0;
        r_rr_ptr <= '0;
        r_pop    <= '0;
        r_push   <= '0;
        r_pkt    <= '0;
        r_busy   <= 1'b0;
      end else begin
        r_pop  <= w_pop_nxt;
        r_push <= w_push_nxt;
        r_busy <= (w_state_nxt != S_IDLE);
        if (r_state == S_IDLE && w_any) r_grant <= w_winner;
        if (r_state == S_POP) begin
          r_pkt    <= w_head;
          r_rr_ptr <= (r_grant == LAST_IDX) ? '0 : r_grant + IW'(1);
        end
      end
    end

`ifdef ARB_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    // A packet that reaches PUSH with an empty push mask was dropped.
    assign w_drop = (r_state == S_POP) && !(|w_push_nxt);

    always_ff @(posedge clk) begin
      if (!reset)                                  r_drop_cnt <= '0;
      else if (w_drop && r_drop_cnt != 16'hFFFF)   r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign drop_cnt[b*16 +: 16] = r_drop_cnt;
`else
    assign drop_cnt[b*16 +: 16] = 16'h0000;
`endif

    assign pop[b*DRVRS +: DRVRS]  = r_pop;
    assign push[b*DRVRS +: DRVRS] = r_push;
    assign busy[b]                = r_busy;

    for (genvar d = 0; d < DRVRS; d++) begin : g_dev
      assign D_push[(b*DRVRS+d)*PCKG_SZ +: PCKG_SZ] = r_pkt;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: a FIFO model feeds a 1-bus instance, a monitor records each
// pop/push transaction, and per-scenario tasks compare records against queued expectations.
module tb_bus_rr_arbiter;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          mode_rr = 1'b1;

  logic [3:0]    pndng1  = '0;
  logic [63:0]   d_pop1  = '0;
  logic [3:0]    pop1, push1;
  logic [63:0]   d_push1;
  logic [0:0]    busy1;
  logic [15:0]   drop1;

  logic [7:0]    pndng2  = '0;
  logic [127:0]  d_pop2  = '0;
  logic [7:0]    pop2, push2;
  logic [127:0]  d_push2;
  logic [1:0]    busy2;
  logic [31:0]   drop2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] data;
    logic        chk_data;
  } exp_t;

  typedef struct {
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [63:0] data;
    logic        busy_pop;
    logic        busy_push;
    logic        busy_after;
    int          cyc;
  } obs_t;

  exp_t        exp_q[$];
  obs_t        obs_q[$];
  obs_t        pend;
  int          stage = 0;
  logic [15:0] fq [4][$];

  bus_rr_arbiter #(.BITS(1), .DRVRS(4), .PCKG_SZ(16)) dut1 (
    .clk(clk), .reset(reset), .mode_rr(mode_rr), .pndng(pndng1), .D_pop(d_pop1),
    .pop(pop1), .push(push1), .D_push(d_push1), .busy(busy1), .drop_cnt(drop1)
  );

  bus_rr_arbiter #(.BITS(2), .DRVRS(4), .PCKG_SZ(16)) dut2 (
    .clk(clk), .reset(reset), .mode_rr(mode_rr), .pndng(pndng2), .D_pop(d_pop2),
    .pop(pop2), .push(push2), .D_push(d_push2), .busy(busy2), .drop_cnt(drop2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic refresh();
    for (int d = 0; d < 4; d++) begin
      pndng1[d]          = (fq[d].size() > 0);
      d_pop1[d*16 +: 16] = (fq[d].size() > 0) ? fq[d][0] : 16'h0000;
    end
  endtask

  task automatic load(input int d, input logic [15:0] pkt);
    fq[d].push_back(pkt);
    refresh();
  endtask

  // Device FIFO model: show-ahead, advances after the edge that sees its pop strobe.
  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (pop1[d] === 1'b1 && fq[d].size() > 0) void'(fq[d].pop_front());
    end
    #1 refresh();
  end

  // Monitor: pop cycle, push cycle, and the following cycle form one record.
  always @(negedge clk) begin
    if (stage == 2) begin
      pend.busy_after = busy1[0];
      obs_q.push_back(pend);
      stage = 0;
    end else if (stage == 1) begin
      pend.push      = push1;
      pend.data      = d_push1;
      pend.busy_push = busy1[0];
      stage = 2;
    end
    if (stage == 0 && pop1 != 4'b0000) begin
      pend.pop      = pop1;
      pend.busy_pop = busy1[0];
      pend.cyc      = cyc;
      stage = 1;
    end
  end

  task automatic wait_obs(input int n);
    for (int c = 0; c < 200 && obs_q.size() < n; c++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    mode_rr = 1'b1;
    for (int d = 0; d < 4; d++) fq[d].delete();
    refresh();
    pndng2 = '0;
    d_pop2 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    obs_q.delete();
    exp_q.delete();
    stage = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    refresh();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pop1, push1, busy1, drop1} !== 25'd0) begin
      errors++;
      $display("FAIL reset_strobes pop=%b push=%b busy=%b drop=%h want all zero", pop1, push1, busy1, drop1);
    end
    checks++;
    if (d_push1 !== 64'd0) begin
      errors++;
      $display("FAIL reset_d_push got %h want 0", d_push1);
    end
    checks++;
    if ({pop2, push2, busy2, drop2} !== 50'd0) begin
      errors++;
      $display("FAIL reset_bus2_strobes pop=%b push=%b busy=%b drop=%h want all zero", pop2, push2, busy2, drop2);
    end
    checks++;
    if (d_push2 !== 128'd0) begin
      errors++;
      $display("FAIL reset_bus2_d_push got %h want 0", d_push2);
    end
  endtask

  task automatic test_unicast();
    exp_t e; obs_t o; int t0; int k;
    do_reset();
    t0 = cyc;
    load(0, 16'h02AB);
    exp_q.push_back('{pop: 4'b0001, push: 4'b0100, data: 16'h02AB, chk_data: 1'b1});
    wait_obs(1);
    checks++;
    if (obs_q.size() < 1) begin errors++; $display("FAIL unicast_timeout records=%0d want=1", obs_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if ({o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after} !== {e.pop, e.push, 3'b110}) begin
        errors++;
        $display("FAIL unicast_strobes got pop=%b push=%b busy=%b%b%b want pop=%b push=%b busy=110",
                 o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after, e.pop, e.push);
      end
      checks++;
      if (o.data !== {4{e.data}}) begin errors++; $display("FAIL unicast_data got %h want %h", o.data, {4{e.data}}); end
      checks++;
      if (o.cyc !== t0 + 1 + 3*k) begin errors++; $display("FAIL unicast_latency pop cycle %0d want %0d", o.cyc, t0 + 1 + 3*k); end
      k++;
    end
  endtask

  task automatic test_broadcast();
    exp_t e; obs_t o; int t0; int k;
    do_reset();
    t0 = cyc;
    load(1, 16'hFF55);
    exp_q.push_back('{pop: 4'b0010, push: 4'b1101, data: 16'hFF55, chk_data: 1'b1});
    wait_obs(1);
    checks++;
    if (obs_q.size() < 1) begin errors++; $display("FAIL broadcast_timeout records=%0d want=1", obs_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if ({o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after} !== {e.pop, e.push, 3'b110}) begin
        errors++;
        $display("FAIL broadcast_strobes got pop=%b push=%b busy=%b%b%b want pop=%b push=%b busy=110",
                 o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after, e.pop, e.push);
      end
      checks++;
      if (o.data !== {4{e.data}}) begin errors++; $display("FAIL broadcast_data got %h want %h", o.data, {4{e.data}}); end
      checks++;
      if (o.cyc !== t0 + 1 + 3*k) begin errors++; $display("FAIL broadcast_latency pop cycle %0d want %0d", o.cyc, t0 + 1 + 3*k); end
      k++;
    end
  endtask

  task automatic test_rr_fairness();
    exp_t e; obs_t o; int t0; int k;
    logic [3:0] oh;
    do_reset();
    t0 = cyc;
    for (int n = 0; n < 3; n++)
      for (int d = 0; d < 4; d++) load(d, 16'h00A0 + 16'(d));
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      if (g % 4 == 0) exp_q.push_back('{pop: oh, push: 4'b0000, data: 16'h0000, chk_data: 1'b0});
      else            exp_q.push_back('{pop: oh, push: 4'b0001, data: 16'h00A0 + 16'(g % 4), chk_data: 1'b1});
    end
    wait_obs(5);
    checks++;
    if (obs_q.size() < 5) begin errors++; $display("FAIL rr_timeout records=%0d want=5", obs_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if ({o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after} !== {e.pop, e.push, 3'b110}) begin
        errors++;
        $display("FAIL rr_grant%0d got pop=%b push=%b busy=%b%b%b want pop=%b push=%b busy=110",
                 k, o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after, e.pop, e.push);
      end
      if (e.chk_data) begin
        checks++;
        if (o.data !== {4{e.data}}) begin errors++; $display("FAIL rr_data%0d got %h want %h", k, o.data, {4{e.data}}); end
      end
      checks++;
      if (o.cyc !== t0 + 1 + 3*k) begin errors++; $display("FAIL rr_spacing%0d pop cycle %0d want %0d", k, o.cyc, t0 + 1 + 3*k); end
      k++;
    end
  endtask

  task automatic test_fixed_priority();
    exp_t e; obs_t o; int t0; int k;
    do_reset();
    mode_rr = 1'b0;
    t0 = cyc;
    for (int n = 0; n < 3; n++)
      for (int d = 0; d < 4; d++) load(d, 16'h00B0 + 16'(d));
    for (int g = 0; g < 3; g++) exp_q.push_back('{pop: 4'b0001, push: 4'b0000, data: 16'h0000, chk_data: 1'b0});
    wait_obs(3);
    checks++;
    if (obs_q.size() < 3) begin errors++; $display("FAIL fixed_timeout records=%0d want=3", obs_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if ({o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after} !== {e.pop, e.push, 3'b110}) begin
        errors++;
        $display("FAIL fixed_grant%0d got pop=%b push=%b busy=%b%b%b want pop=%b push=%b busy=110",
                 k, o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after, e.pop, e.push);
      end
      checks++;
      if (o.cyc !== t0 + 1 + 3*k) begin errors++; $display("FAIL fixed_spacing%0d pop cycle %0d want %0d", k, o.cyc, t0 + 1 + 3*k); end
      k++;
    end
  endtask

  task automatic test_drop();
    exp_t e; obs_t o; int t0; int k;
    logic [15:0] want_drop;
`ifdef ARB_DROP_CNT_EN
    want_drop = 16'd2;
`else
    want_drop = 16'd0;
`endif
    do_reset();
    t0 = cyc;
    load(2, 16'h0712);
    load(3, 16'h0334);
    exp_q.push_back('{pop: 4'b0100, push: 4'b0000, data: 16'h0000, chk_data: 1'b0});
    exp_q.push_back('{pop: 4'b1000, push: 4'b0000, data: 16'h0000, chk_data: 1'b0});
    wait_obs(2);
    checks++;
    if (obs_q.size() < 2) begin errors++; $display("FAIL drop_timeout records=%0d want=2", obs_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if ({o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after} !== {e.pop, e.push, 3'b110}) begin
        errors++;
        $display("FAIL drop_case%0d got pop=%b push=%b busy=%b%b%b want pop=%b push=%b busy=110",
                 k, o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after, e.pop, e.push);
      end
      checks++;
      if (o.cyc !== t0 + 1 + 3*k) begin errors++; $display("FAIL drop_spacing%0d pop cycle %0d want %0d", k, o.cyc, t0 + 1 + 3*k); end
      k++;
    end
    @(negedge clk);
    checks++;
    if (drop1 !== want_drop) begin errors++; $display("FAIL drop_count got %0d want %0d", drop1, want_drop); end
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o; int t0; int k;
    do_reset();
    load(2, 16'h0955);
    wait_obs(1);
    checks++;
    if (obs_q.size() < 1 || obs_q[0].pop !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_first_grant records=%0d want one grant to dev2", obs_q.size());
    end
    @(negedge clk);
    load(1, 16'h0266);
    for (int c = 0; c < 20 && pop1[1] !== 1'b1; c++) @(negedge clk);
    checks++;
    if (pop1[1] !== 1'b1) begin errors++; $display("FAIL rstmid_pop_timeout pop=%b want bit1 set", pop1); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({push1, busy1, drop1} !== 21'd0) begin
      errors++;
      $display("FAIL rstmid_strobes push=%b busy=%b drop=%h want all zero", push1, busy1, drop1);
    end
    checks++;
    if (d_push1 !== 64'd0) begin errors++; $display("FAIL rstmid_d_push got %h want 0", d_push1); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    t0 = cyc;
    load(0, 16'h0377);
    load(3, 16'h0088);
    exp_q.push_back('{pop: 4'b0001, push: 4'b1000, data: 16'h0377, chk_data: 1'b1});
    exp_q.push_back('{pop: 4'b1000, push: 4'b0001, data: 16'h0088, chk_data: 1'b1});
    wait_obs(2);
    checks++;
    if (obs_q.size() < 2) begin errors++; $display("FAIL rstmid_timeout records=%0d want=2", obs_q.size()); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if ({o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after} !== {e.pop, e.push, 3'b110}) begin
        errors++;
        $display("FAIL rstmid_grant%0d got pop=%b push=%b busy=%b%b%b want pop=%b push=%b busy=110",
                 k, o.pop, o.push, o.busy_pop, o.busy_push, o.busy_after, e.pop, e.push);
      end
      checks++;
      if (o.data !== {4{e.data}}) begin errors++; $display("FAIL rstmid_data%0d got %h want %h", k, o.data, {4{e.data}}); end
      checks++;
      if (o.cyc !== t0 + 1 + 3*k) begin errors++; $display("FAIL rstmid_spacing%0d pop cycle %0d want %0d", k, o.cyc, t0 + 1 + 3*k); end
      k++;
    end
  endtask

  task automatic test_two_buses();
    logic [127:0] want_data;
    want_data = {{4{16'h0222}}, {4{16'h0111}}};
    do_reset();
    pndng2 = 8'b1000_0001;
    d_pop2[0*16 +: 16] = 16'h0111;
    d_pop2[7*16 +: 16] = 16'h0222;
    @(negedge clk);
    checks++;
    if ({pop2, busy2} !== {8'b1000_0001, 2'b11}) begin
      errors++;
      $display("FAIL two_bus_pop pop=%b busy=%b want pop=10000001 busy=11", pop2, busy2);
    end
    @(negedge clk);
    pndng2 = '0;
    checks++;
    if ({pop2, push2, busy2} !== {8'b0000_0000, 8'b0100_0010, 2'b11}) begin
      errors++;
      $display("FAIL two_bus_push pop=%b push=%b busy=%b want pop=00000000 push=01000010 busy=11", pop2, push2, busy2);
    end
    checks++;
    if (d_push2 !== want_data) begin errors++; $display("FAIL two_bus_data got %h want %h", d_push2, want_data); end
    @(negedge clk);
    checks++;
    if ({push2, busy2, drop2} !== 42'd0) begin
      errors++;
      $display("FAIL two_bus_idle push=%b busy=%b drop=%h want all zero", push2, busy2, drop2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    refresh();
    test_reset();
    test_unicast();
    test_broadcast();
    test_rr_fairness();
    test_fixed_priority();
    test_drop();
    test_reset_mid();
    test_two_buses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
